// File: rtl/sensor_avg_pkg.sv
// Shared constants, types and width helper for the sensor averaging bank.
package sensor_avg_pkg;

  localparam int MAX_SHIFT_DEF = 7;
  localparam int TICK_W_FAST   = 16;
  localparam int TICK_W_SLOW   = 22;

  typedef logic [2:0] shift_t;

  function automatic int acc_w(input int data_w, input int max_shift);
    return data_w + max_shift;
  endfunction

endpackage

// File: rtl/exp_avg_dp.sv
// Shared combinational exponential-average step: seed load or acc - acc>>k + sample.
module exp_avg_dp
  import sensor_avg_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 19
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] sample,
  input  shift_t            k,
  input  logic              seed,
  output logic [ACC_W-1:0]  acc_nxt
);

  logic [ACC_W-1:0] sample_ext;

  always_comb begin
    sample_ext = ACC_W'(sample);
    // Seeding preloads the steady-state value so avg equals the sample at once.
    if (seed) begin
      acc_nxt = sample_ext << k;
    end else begin
      acc_nxt = acc - (acc >> k) + sample_ext;
    end
  end

endmodule

// File: rtl/sensor_avg_bank.sv
// Multi-channel exponential averager: per-channel capture/pending, round-robin
// grant into one shared update datapath, optional internal sample timer.
module sensor_avg_bank
  import sensor_avg_pkg::*;
#(
  parameter int                NUM_CH     = 4,
  parameter int                DATA_W     = 12,
  parameter int                MAX_SHIFT  = MAX_SHIFT_DEF,
  parameter logic [NUM_CH-1:0] TIMED_MASK = {{(NUM_CH-1){1'b0}}, 1'b1},
  parameter bit                FAST_SIM   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] smpl_in,
  input  logic [NUM_CH-1:0]        smpl_req,
  input  logic [NUM_CH-1:0]        seed,
  input  logic [NUM_CH*3-1:0]      shift,
  input  logic                     ovr_clr,
  output logic [NUM_CH*DATA_W-1:0] avg,
  output logic [NUM_CH-1:0]        avg_vld,
  output logic [NUM_CH-1:0]        overrun,
  output logic                     tick
);

  localparam int     ACC_W  = acc_w(DATA_W, MAX_SHIFT);
  localparam int     TICK_W = FAST_SIM ? TICK_W_FAST : TICK_W_SLOW;
  localparam int     PTR_W  = $clog2(NUM_CH);
  localparam shift_t K_MAX  = (MAX_SHIFT < 7) ? shift_t'(MAX_SHIFT) : 3'd7;

  logic [TICK_W-1:0] tmr;
  logic [ACC_W-1:0]  acc  [NUM_CH];
  logic [DATA_W-1:0] hold [NUM_CH];
  shift_t            k    [NUM_CH];
  logic [NUM_CH-1:0] pending, seed_pend, req_eff, evt, gnt_clr;
  logic [PTR_W-1:0]  ptr, gnt_idx, ptr_nxt;
  logic              gnt_vld;
  logic [ACC_W-1:0]  acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) tmr <= '0;
    else     tmr <= tmr + 1'b1;
  end

  assign tick    = &tmr;
  assign req_eff = (TIMED_MASK & {NUM_CH{tick}}) | (~TIMED_MASK & smpl_req);
  assign evt     = req_eff | seed;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      k[c] = (shift[c*3 +: 3] > K_MAX) ? K_MAX : shift[c*3 +: 3];
    end
  end

  // Rotating priority: first pending channel at or after ptr, wrapping around.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!gnt_vld && pending[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(j);
      end
    end
  end

  assign gnt_clr = gnt_vld ? (NUM_CH'(1) << gnt_idx) : '0;
  assign ptr_nxt = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;

  exp_avg_dp #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_dp (
    .acc     (acc[gnt_idx]),
    .sample  (hold[gnt_idx]),
    .k       (k[gnt_idx]),
    .seed    (seed_pend[gnt_idx]),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c]  <= '0;
        hold[c] <= '0;
      end
      pending   <= '0;
      seed_pend <= '0;
      overrun   <= '0;
      avg_vld   <= '0;
      ptr       <= '0;
    end else begin
      avg_vld <= gnt_clr;
      if (gnt_vld) begin
        acc[gnt_idx] <= acc_nxt;
        ptr          <= ptr_nxt;
      end
      // New events win over the grant clear; a refill in the grant cycle is not an overrun.
      pending   <= (pending & ~gnt_clr) | evt;
      seed_pend <= (seed_pend & ~gnt_clr) | seed;
      overrun   <= (overrun & ~{NUM_CH{ovr_clr}}) | (evt & pending & ~gnt_clr);
      for (int c = 0; c < NUM_CH; c++) begin
        if (evt[c]) hold[c] <= smpl_in[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    avg = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      avg[c*DATA_W +: DATA_W] = DATA_W'(acc[c] >> k[c]);
    end
  end

endmodule

// File: tb/tb_sensor_avg_bank.sv
// Bench for sensor_avg_bank: event-driven instance plus a timer-driven instance.
module tb_sensor_avg_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] smpl_in = '0;
  logic [3:0]  smpl_req = '0;
  logic [3:0]  seed = '0;
  logic [11:0] shift = '0;
  logic        ovr_clr = 1'b0;
  logic [47:0] avg;
  logic [3:0]  avg_vld, overrun;
  logic        tick;

  logic [3:0]  smpl_req_t = '0;
  logic [3:0]  seed_t = '0;
  logic [47:0] avg_t;
  logic [3:0]  avg_vld_t, overrun_t;
  logic        tick_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] sb_e;

  typedef struct {
    int          ch;
    logic [2:0]  sh;
    logic [11:0] smp;
    logic        sd;
    logic [11:0] exp_avg;
  } vec_t;
  vec_t vecs[11];

  always #5 clk = ~clk;

  sensor_avg_bank #(.TIMED_MASK(4'b0000)) dut (
    .clk(clk), .rst(rst), .smpl_in(smpl_in), .smpl_req(smpl_req), .seed(seed),
    .shift(shift), .ovr_clr(ovr_clr), .avg(avg), .avg_vld(avg_vld),
    .overrun(overrun), .tick(tick)
  );

  sensor_avg_bank dut_t (
    .clk(clk), .rst(rst), .smpl_in(smpl_in), .smpl_req(smpl_req_t), .seed(seed_t),
    .shift(shift), .ovr_clr(ovr_clr), .avg(avg_t), .avg_vld(avg_vld_t),
    .overrun(overrun_t), .tick(tick_t)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard: every avg_vld pulse must match the oldest expected {ch, avg}.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (avg_vld[c]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_vld ch=%0d avg=%0h expected=none", c, avg[c*12 +: 12]);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_channel", c, sb_e[15:12]);
          check("sb_avg", avg[c*12 +: 12], sb_e[11:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    smpl_req = '0;
    seed = '0;
    ovr_clr = 1'b0;
    smpl_req_t = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_smpl(input int ch, input logic [11:0] v);
    smpl_in[ch*12 +: 12] = v;
  endtask

  task automatic set_shift(input int ch, input logic [2:0] v);
    shift[ch*3 +: 3] = v;
  endtask

  task automatic pulse(input logic [3:0] req, input logic [3:0] sd);
    smpl_req = req;
    seed = sd;
    step();
    smpl_req = '0;
    seed = '0;
  endtask

  task automatic push_exp(input int ch, input logic [11:0] v);
    exp_q.push_back({4'(ch), v});
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    step();
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Channels 0/1 occupy the arbiter while channel 2 is requested on two back-to-back edges.
  task automatic run_overrun();
    shift = '0;
    set_smpl(0, 12'h0A0);
    set_smpl(1, 12'h0B1);
    set_smpl(2, 12'h111);
    push_exp(0, 12'h0A0);
    push_exp(1, 12'h0B1);
    push_exp(2, 12'h222);
    smpl_req = 4'b0011;
    step();
    smpl_req = 4'b0100;
    step();
    set_smpl(2, 12'h222);
    step();
    smpl_req = '0;
    wait_drain(10);
    check("overrun_set", overrun, 4'b0100);
  endtask

  initial begin
    int cnt;
    logic [3:0] vld_seen;

    vecs[0]  = '{0, 3'd2, 12'h400, 1'b0, 12'h100};
    vecs[1]  = '{0, 3'd2, 12'h400, 1'b0, 12'h1C0};
    vecs[2]  = '{0, 3'd2, 12'h400, 1'b0, 12'h250};
    vecs[3]  = '{0, 3'd2, 12'h400, 1'b0, 12'h2BC};
    vecs[4]  = '{1, 3'd5, 12'h123, 1'b1, 12'h123};
    vecs[5]  = '{1, 3'd5, 12'h123, 1'b0, 12'h123};
    vecs[6]  = '{2, 3'd0, 12'hABC, 1'b0, 12'hABC};
    vecs[7]  = '{2, 3'd0, 12'h005, 1'b0, 12'h005};
    vecs[8]  = '{3, 3'd7, 12'hFFF, 1'b1, 12'hFFF};
    vecs[9]  = '{3, 3'd7, 12'h000, 1'b0, 12'hFDF};
    vecs[10] = '{1, 3'd4, 12'h123, 1'b0, 12'h233};

    do_reset();
    check("rst_avg", avg, 0);
    check("rst_avg_vld", avg_vld, 0);
    check("rst_overrun", overrun, 0);
    check("rst_tick", tick, 0);
    check("rst_avg_timed", avg_t, 0);

    // All four request together with the pointer at 0.
    shift = '0;
    for (int c = 0; c < 4; c++) begin
      set_smpl(c, 12'(12'h111 * (c + 1)));
      push_exp(c, 12'(12'h111 * (c + 1)));
    end
    pulse(4'b1111, 4'b0000);
    for (int c = 0; c < 4; c++) begin
      step();
      check("contention_vld", avg_vld, 4'b0001 << c);
    end
    push_exp(0, 12'h111);
    push_exp(1, 12'h222);
    pulse(4'b0011, 4'b0000);
    wait_drain(10);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      set_shift(vecs[i].ch, vecs[i].sh);
      set_smpl(vecs[i].ch, vecs[i].smp);
      push_exp(vecs[i].ch, vecs[i].exp_avg);
      if (vecs[i].sd) pulse(4'b0000, 4'b0001 << vecs[i].ch);
      else            pulse(4'b0001 << vecs[i].ch, 4'b0000);
      wait_drain(8);
    end

    do_reset();
    run_overrun();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("ovr_clr", overrun, 0);

    // Reset lands while channels 1 and 3 are still pending.
    do_reset();
    run_overrun();
    smpl_req = 4'b1010;
    step();
    smpl_req = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    vld_seen = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      vld_seen |= avg_vld;
    end
    check("midrst_no_vld", vld_seen, 0);
    check("midrst_avg", avg, 0);
    check("midrst_overrun", overrun, 0);

    // Timer: first tick 2^16-1 cycles after reset; ch0 of dut_t ignores its request.
    do_reset();
    shift = '0;
    set_smpl(0, 12'h5A5);
    cnt = 0;
    vld_seen = '0;
    while (tick_t !== 1'b1 && cnt < 70000) begin
      smpl_req_t = (cnt % 1000 == 999) ? 4'b0001 : 4'b0000;
      step();
      cnt++;
      vld_seen |= avg_vld_t;
    end
    smpl_req_t = '0;
    check("tick_period", cnt, 65535);
    check("tick_main", tick, 1);
    check("timed_ignores_req", vld_seen, 0);
    step();
    check("tick_one_cycle", tick_t, 0);
    step();
    check("timed_vld", avg_vld_t, 4'b0001);
    check("timed_avg", avg_t[11:0], 12'h5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sensor_avg_bank.md
Name: sensor_avg_bank

Overview:
- Parametrised, multi-channel exponential-averaging engine for eBike sensor conditioning (current, torque, battery, future channels).
- Generalises the fixed 2-channel averaging in the sensor-conditioning path: per-channel window (shift), event- or timer-driven updates, seeding, and one shared round-robin update datapath.
- Sits between the A2D/cadence front end and desiredDrive/telemetry. Consumers read per-channel averages plus a one-cycle valid pulse.

Parameters:
- NUM_CH, 4, number of channels (2..8).
- DATA_W, 12, sample and average width.
- MAX_SHIFT, 7, largest averaging shift; accumulator width ACC_W = DATA_W+MAX_SHIFT.
- TIMED_MASK, 4'b0001, bit set = channel driven by the internal sample tick (its smpl_req is ignored).
- FAST_SIM, 1, 1: tick period 2^16 clk; 0: tick period 2^22 clk.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- smpl_in  in  NUM_CH*DATA_W  packed samples; channel c is at [c*DATA_W +: DATA_W]
- smpl_req  in  NUM_CH  per-channel update request pulse (e.g. cadence_rise)
- seed  in  NUM_CH  per-channel seed pulse (e.g. pedaling resumes)
- shift  in  NUM_CH*3  per-channel window log2; quasi-static
- ovr_clr  in  1  clears all overrun flags
- avg  out  NUM_CH*DATA_W  per-channel average = acc[c] >> shift[c], low DATA_W bits
- avg_vld  out  NUM_CH  one-cycle pulse after channel c's accumulator is written
- overrun  out  NUM_CH  sticky: a request arrived while channel c was still pending
- tick  out  1  internal sample-timer pulse, exported for telemetry pacing

Behaviour:
- Reset (rst high at a clk edge) clears: all accumulators, hold registers, pending, seed_pend, overrun, avg_vld, RR pointer, and the timer. After reset, avg = 0 on all channels and tick = 0.
- Timer:
  - Free-running counter, 16 or 22 bits. tick = counter all-ones; the counter wraps to 0 on the next edge.
  - First tick occurs 2^N-1 cycles after reset.
- Request:
  - Effective request for channel c: req_c = TIMED_MASK[c] ? tick : smpl_req[c].
  - On req_c or seed[c], smpl_in[c] is captured into hold[c] and pending[c] is set at the same edge.
  - seed[c] additionally sets seed_pend[c]. If seed and req occur in the same cycle, it is one seed.
- Overrun:
  - If req_c or seed[c] arrives while pending[c] is already set, overrun[c] is set.
  - hold[c] is overwritten with the newest sample, so only one update is performed.
  - seed_pend is ORed in, so a seed is never lost.
  - ovr_clr clears overrun. If ovr_clr and a new overrun occur in the same cycle, set wins.
- Arbiter:
  - Combinational, over pending. Grants the lowest pending index at or above the RR pointer, with wrap.
  - One grant per cycle. On each grant the pointer advances to grant+1 (mod NUM_CH).
- Update (edge after grant):
  - k = min(shift[c], MAX_SHIFT).
  - Seed: acc[c] <= hold[c] << k, so avg equals the sample immediately.
  - Otherwise: acc[c] <= acc[c] - (acc[c] >> k) + hold[c]. This is width ACC_W, unsigned.
  - The steady-state maximum (2^DATA_W - 1) << k fits in ACC_W, so no saturation is needed.
  - The same edge clears pending[c] and seed_pend[c] and registers avg_vld[c] = 1 for one cycle.
  - A new request for c in the grant cycle re-sets pending (set has priority over clear) and does not flag overrun.
- Latency:
  - Uncontended: request at edge t, accumulator written at edge t+1, avg/avg_vld valid after t+1.
  - Worst case: NUM_CH cycles.
- shift = 0 gives pass-through (acc = sample). A shift change takes effect on the next update; the accumulator is not rescaled.
- avg is combinational from acc and shift (no extra latency).
- rst asserted mid-arbitration discards all pending work. No avg_vld occurs in the cycle after reset.

Decomposition:
- Package sensor_avg_pkg holds:
  - Constants: MAX_SHIFT default, TICK_W_FAST = 16, TICK_W_SLOW = 22.
  - Function acc_w(DATA_W, MAX_SHIFT).
  - Typedef shift_t (3-bit).
- One sub-module, exp_avg_dp: a single shared, purely combinational update datapath.
  - Inputs: acc, sample, k, seed.
  - Output: next acc.
  - Instanced once and muxed by the grant, which keeps area flat in NUM_CH.

Test Plan:
- Reset/steady: shift0 = 2, smpl_in0 = 0x400, smpl_req0 pulsed every 8 clk -> avg0 = 0x100, 0x1C0, 0x250 on successive avg_vld0 pulses, converging to 0x400. All outputs 0 after rst.
- Seed: shift1 = 5, seed1 with smpl_in1 = 0x123 -> one cycle later avg1 = 0x123, acc1 = 0x2460. A subsequent req with 0x123 keeps avg1 = 0x123.
- Contention: smpl_req = 4'b1111 in one cycle, pointer 0 -> avg_vld = 0001, 0010, 0100, 1000 on four consecutive cycles. Pointer ends at 0.
- Overrun: two smpl_req2 pulses one cycle apart while channels 0/1 hold the arbiter -> overrun2 = 1, a single update using the second sample. ovr_clr clears it.
- Timer: FAST_SIM = 1, TIMED_MASK = 4'b0001 -> tick every 65536 clk, ch0 updates only on tick, smpl_req0 pulses ignored.
- Reset mid-operation: rst asserted with pending = 4'b1010 -> no avg_vld after release, avg = 0, overrun = 0.
